nvm_synapse_array_ctrl: RTL and testbench

- Wishbone slave front-end that fans one host transaction out to NUM_MACRO Neuromorphic X1 macros (32x32 each) and collects their responses.
- Each macro owns one synapse bit position: bit i of the host data programs, or reads, macro i.
- Adds per-macro handshake tracking, an enable mask, a programmable ack timeout and a status register.
- Sits between the caravel user-project Wishbone bus and the X1 macro array in SNN_gesture.

---
 rtl/nvm_synapse_array_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_nvm_synapse_array_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_synapse_array_ctrl.sv
// Wishbone slave that fans one host DATA access out to an array of X1 synapse macros,
// one synapse bit per macro, with enable mask, ack timeout and status reporting.
module nvm_synapse_array_ctrl #(
  parameter int unsigned NUM_MACRO   = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] MACRO_ADDR  = 32'h3000_000C,
  parameter logic [7:0]  MEM_HIGH    = 8'hFF,
  parameter logic [7:0]  MEM_LOW     = 8'h00,
  parameter logic [15:0] TIMEOUT_RST = 16'd1024
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic [31:0]               wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic [NUM_MACRO-1:0]      m_cyc_o,
  output logic [NUM_MACRO-1:0]      m_stb_o,
  output logic                      m_we_o,
  output logic [3:0]                m_sel_o,
  output logic [31:0]               m_adr_o,
  output logic [NUM_MACRO*32-1:0]   m_dat_o,
  input  logic [NUM_MACRO*32-1:0]   m_dat_i,
  input  logic [NUM_MACRO-1:0]      m_ack_i,
  output logic                      done_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [NUM_MACRO-1:0]  en_q, en_d;
  logic [NUM_MACRO-1:0]  stb_q, stb_d;
  logic [NUM_MACRO-1:0]  ack_mask_q, ack_mask_d;
  logic [NUM_MACRO-1:0]  rd_q, rd_d;
  logic [NUM_MACRO-1:0]  wbits_q, wbits_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [15:0]           tcnt_q, tcnt_d;
  logic                  tflag_q, tflag_d;
  logic                  wack_q, wack_d;
  logic [31:0]           dat_q, dat_d;

  logic                  req;
  logic                  busy;
  logic [NUM_MACRO-1:0]  m_bit;
  logic [NUM_MACRO-1:0]  hit_ack;
  logic [31:0]           ack32, en32, rd32;
  logic                  unused_ok;

  assign req       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign busy      = (state_q != IDLE);
  assign unused_ok = ^{wbs_adr_i[1:0], m_dat_i};

  always_comb begin
    m_bit = '0;
    for (int unsigned i = 0; i < NUM_MACRO; i++) begin
      m_bit[i] = m_dat_i[i*32];
    end
  end

  // stb_q doubles as the pending mask: a macro stays strobed until it acks
  assign hit_ack = m_ack_i & stb_q;

  always_comb begin
    ack32 = '0;
    en32  = '0;
    rd32  = '0;
    ack32[NUM_MACRO-1:0] = ack_mask_q;
    en32[NUM_MACRO-1:0]  = en_q;
    rd32[NUM_MACRO-1:0]  = rd_d;
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    stb_d      = stb_q;
    ack_mask_d = ack_mask_q;
    rd_d       = rd_q;
    wbits_d    = wbits_q;
    we_d       = we_q;
    sel_d      = sel_q;
    tmo_d      = tmo_q;
    tcnt_d     = tcnt_q;
    tflag_d    = tflag_q;
    wack_d     = 1'b0;
    dat_d      = '0;

    if (state_q == ISSUE || state_q == WAIT) begin
      stb_d      = stb_q & ~hit_ack;
      ack_mask_d = ack_mask_q | hit_ack;
      if (!we_q) begin
        rd_d = rd_q | (hit_ack & m_bit);
      end
    end

    case (state_q)
      IDLE: begin
        if (req && !wack_q) begin
          if (wbs_adr_i[3:2] == 2'd0) begin
            state_d    = ISSUE;
            we_d       = wbs_we_i;
            sel_d      = wbs_sel_i;
            wbits_d    = wbs_dat_i[NUM_MACRO-1:0];
            ack_mask_d = '0;
            rd_d       = '0;
            stb_d      = en_q;
            tcnt_d     = tmo_q;
          end else begin
            wack_d = 1'b1;
            case (wbs_adr_i[3:2])
              2'd1: begin
                dat_d = {tflag_q, busy, 14'b0, ack32[15:0]};
                if (!wbs_we_i) begin
                  tflag_d = 1'b0;
                end
              end
              2'd2: begin
                dat_d = en32;
                if (wbs_we_i) begin
                  en_d = wbs_dat_i[NUM_MACRO-1:0];
                end
              end
              default: begin
                dat_d = {ack32[31:16], tmo_q};
                if (wbs_we_i) begin
                  tmo_d = wbs_dat_i[15:0];
                end
              end
            endcase
          end
        end
      end
      ISSUE: begin
        if (stb_q == '0) begin
          state_d = RESP;
          dat_d   = we_q ? '0 : rd32;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (stb_q == '0) begin
          state_d = RESP;
          dat_d   = we_q ? '0 : rd32;
        end else if (tcnt_q == '0) begin
          state_d = RESP;
          stb_d   = '0;
          tflag_d = 1'b1;
          dat_d   = we_q ? '0 : rd32;
        end else begin
          tcnt_d = tcnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      en_q       <= '1;
      stb_q      <= '0;
      ack_mask_q <= '0;
      rd_q       <= '0;
      wbits_q    <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      tmo_q      <= TIMEOUT_RST;
      tcnt_q     <= '0;
      tflag_q    <= 1'b0;
      wack_q     <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      stb_q      <= stb_d;
      ack_mask_q <= ack_mask_d;
      rd_q       <= rd_d;
      wbits_q    <= wbits_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      tmo_q      <= tmo_d;
      tcnt_q     <= tcnt_d;
      tflag_q    <= tflag_d;
      wack_q     <= wack_d;
      dat_q      <= dat_d;
    end
  end

  always_comb begin
    m_dat_o = '0;
    for (int unsigned i = 0; i < NUM_MACRO; i++) begin
      m_dat_o[i*32 +: 32] = {24'h0, wbits_q[i] ? MEM_HIGH : MEM_LOW};
    end
  end

  assign m_cyc_o   = stb_q;
  assign m_stb_o   = stb_q;
  assign m_we_o    = we_q;
  assign m_sel_o   = sel_q;
  assign m_adr_o   = MACRO_ADDR;
  assign wbs_ack_o = wack_q | (state_q == RESP);
  assign wbs_dat_o = dat_q;
  assign done_o    = (state_q == RESP);

endmodule

// File: tb/tb_nvm_synapse_array_ctrl.sv
// Directed bench for nvm_synapse_array_ctrl: register vectors from a table plus
// hand-written DATA sequences against a simple per-macro ack-delay model.
module tb_nvm_synapse_array_ctrl;
  localparam int NM = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]      sel = 4'hF;
  logic [31:0]     adr = '0, wdat = '0;
  logic [31:0]     wbs_dat_o;
  logic            wbs_ack_o;
  logic [NM-1:0]   m_cyc_o, m_stb_o, m_ack;
  logic            m_we_o, done_o;
  logic [3:0]      m_sel_o;
  logic [31:0]     m_adr_o;
  logic [NM*32-1:0] m_dat_o, m_dat_i;

  int              dly [NM];
  logic [NM-1:0]   rbits = '0;
  int              cnt [NM];
  int              checks = 0, failures = 0;
  int              ack_cnt = 0, done_cnt = 0, stb_cycles = 0;
  logic            mon_en = 1'b0;
  logic [NM-1:0]   prev_stb = '0, prev_ack = '0;
  int              drop_err = 0, drops = 0;

  always #5 clk = ~clk;

  nvm_synapse_array_ctrl #(.NUM_MACRO(NM), .TIMEOUT_RST(16'd1024)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack), .done_o(done_o)
  );

  // Macro model: macro i acks in the dly[i]-th cycle of its strobe; dly 0 never acks
  always @(posedge clk) begin
    for (int i = 0; i < NM; i++) cnt[i] <= m_stb_o[i] ? cnt[i] + 1 : 0;
  end

  always_comb begin
    m_ack   = '0;
    m_dat_i = '0;
    for (int i = 0; i < NM; i++) begin
      m_ack[i] = m_stb_o[i] && (dly[i] != 0) && (cnt[i] == dly[i] - 1);
      m_dat_i[i*32 +: 32] = {31'h0, rbits[i]};
    end
  end

  always @(negedge clk) begin
    int e, d;
    e = 0; d = 0;
    if (wbs_ack_o) ack_cnt <= ack_cnt + 1;
    if (done_o) done_cnt <= done_cnt + 1;
    if (m_stb_o != '0) stb_cycles <= stb_cycles + 1;
    if (mon_en) begin
      for (int i = 0; i < NM; i++) begin
        if (prev_stb[i] && prev_ack[i]) begin
          if (m_stb_o[i]) e++; else d++;
        end else if (prev_stb[i] && !m_stb_o[i]) e++;
      end
    end
    drop_err <= drop_err + e;
    drops    <= drops + d;
    prev_stb <= m_stb_o;
    prev_ack <= m_ack;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Call just after a rising edge; leaves one idle cycle after the ack
  task automatic wb_xfer(input logic w, input logic [3:0] off, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
    adr = BASE + {28'h0, off}; we = w; wdat = wd; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!wbs_ack_o && lat < 200);
    rd = wbs_dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_dly(input int v);
    for (int i = 0; i < NM; i++) dly[i] = v;
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs [12];
    logic [31:0] rd, exp;
    int          lat, a0, d0, s0, a1, a2, r2;
    logic [NM-1:0] pstb;

    vecs[0]  = '{1'b0, 4'h8, 32'h0,         32'h0000_FFFF};
    vecs[1]  = '{1'b0, 4'hC, 32'h0,         32'h0000_0400};
    vecs[2]  = '{1'b0, 4'h4, 32'h0,         32'h0000_0000};
    vecs[3]  = '{1'b1, 4'h8, 32'h0000_1234, 32'h0};
    vecs[4]  = '{1'b0, 4'h8, 32'h0,         32'h0000_1234};
    vecs[5]  = '{1'b1, 4'hC, 32'hABCD_0010, 32'h0};
    vecs[6]  = '{1'b0, 4'hC, 32'h0,         32'h0000_0010};
    vecs[7]  = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 4'h4, 32'h0,         32'h0000_0000};
    vecs[9]  = '{1'b1, 4'h8, 32'h0000_FFFF, 32'h0};
    vecs[10] = '{1'b1, 4'hC, 32'h0000_0400, 32'h0};
    vecs[11] = '{1'b0, 4'hC, 32'h0,         32'h0000_0400};
    set_dly(0);

    // Reset state
    #12;
    chk("rst_stb", {16'h0, m_stb_o}, 32'h0);
    chk("rst_ack_done", {30'h0, wbs_ack_o, done_o}, 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Register table
    for (int v = 0; v < 12; v++) begin
      wb_xfer(vecs[v].w, vecs[v].off, vecs[v].wd, rd, lat);
      chk($sformatf("vec%0d_lat", v), lat, 1);
      if (!vecs[v].w) chk($sformatf("vec%0d_rd", v), rd, vecs[v].exp);
    end

    // Write DATA 0xA5A5, all macros ack in their 2nd strobe cycle
    set_dly(2);
    a0 = ack_cnt; d0 = done_cnt;
    wb_xfer(1'b1, 4'h0, 32'h0000_A5A5, rd, lat);
    chk("wr_lat", lat, 4);
    chk("wr_rd", rd, 32'h0);
    chk("wr_acks", ack_cnt - a0, 1);
    chk("wr_done", done_cnt - d0, 1);
    chk("wr_we", {31'h0, m_we_o}, 32'h1);
    chk("wr_adr", m_adr_o, 32'h3000_000C);
    rd = 32'h0000_A5A5;
    for (int i = 0; i < NM; i++) begin
      exp = rd[i] ? 32'h0000_00FF : 32'h0;
      chk($sformatf("wr_mdat%0d", i), m_dat_o[i*32 +: 32], exp);
    end
    wb_xfer(1'b0, 4'h4, 32'h0, rd, lat);
    chk("wr_status", rd, 32'h0000_FFFF);

    // Read with staggered acks 1..16, macro i returns i[0]
    for (int i = 0; i < NM; i++) begin
      dly[i] = i + 1;
      rbits[i] = i[0];
    end
    mon_en = 1'b1;
    wb_xfer(1'b0, 4'h0, 32'h0, rd, lat);
    mon_en = 1'b0;
    chk("rd_data", rd, 32'h0000_AAAA);
    chk("rd_lat", lat, 18);
    chk("rd_stb_drop_err", drop_err, 0);
    chk("rd_stb_drops", drops, 16);

    // Second DATA access while busy is held off until the first RESP
    set_dly(4);
    a1 = 0; a2 = 0; r2 = 0; pstb = '0;
    adr = BASE; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (wbs_ack_o) begin
        if (a1 == 0) a1 = k;
        else if (a2 == 0) a2 = k;
      end
      if (k > 1 && pstb == '0 && m_stb_o != '0 && r2 == 0) begin
        r2 = k;
        chk("hold_mdat0", m_dat_o[31:0], 32'h0000_00FF);
        chk("hold_mdat4", m_dat_o[159:128], 32'h0000_0000);
      end
      if (k == 3) begin
        we = 1'b1; wdat = 32'h0000_0F0F; cyc = 1'b1; stb = 1'b1;
      end
      if (a2 != 0) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end
      pstb = m_stb_o;
      @(posedge clk); #1;
    end
    chk("hold_ack1", a1, 6);
    chk("hold_issue2", r2, 8);
    chk("hold_ack2", a2, 13);

    // Timeout: ENABLE=0x00FF, TIMEOUT=8, macro 3 silent
    wb_xfer(1'b1, 4'h8, 32'h0000_00FF, rd, lat);
    wb_xfer(1'b1, 4'hC, 32'h0000_0008, rd, lat);
    for (int i = 0; i < NM; i++) dly[i] = (i < 8 && i != 3) ? i + 1 : 0;
    wb_xfer(1'b0, 4'h0, 32'h0, rd, lat);
    chk("tmo_lat", lat, 11);
    chk("tmo_data", rd, 32'h0000_00A2);
    wb_xfer(1'b0, 4'h4, 32'h0, rd, lat);
    chk("tmo_status1", rd, 32'h8000_00F7);
    wb_xfer(1'b0, 4'h4, 32'h0, rd, lat);
    chk("tmo_status2", rd, 32'h0000_00F7);

    // ENABLE=0: no macro strobes, immediate response
    wb_xfer(1'b1, 4'h8, 32'h0, rd, lat);
    s0 = stb_cycles; d0 = done_cnt;
    wb_xfer(1'b1, 4'h0, 32'h0000_FFFF, rd, lat);
    chk("en0_lat", lat, 2);
    chk("en0_stb", stb_cycles - s0, 0);
    chk("en0_done", done_cnt - d0, 1);

    // Asynchronous reset in WAIT abandons the operation
    wb_xfer(1'b1, 4'h8, 32'h0000_0F0F, rd, lat);
    wb_xfer(1'b1, 4'hC, 32'h0000_004D, rd, lat);
    set_dly(0);
    adr = BASE; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_pre_stb", {16'h0, m_stb_o}, 32'h0000_0F0F);
    a0 = ack_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_stb", {16'h0, m_stb_o}, 32'h0);
    chk("arst_cyc", {16'h0, m_cyc_o}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("arst_no_ack", ack_cnt - a0, 0);
    wb_xfer(1'b0, 4'h8, 32'h0, rd, lat);
    chk("arst_enable", rd, 32'h0000_FFFF);
    wb_xfer(1'b0, 4'hC, 32'h0, rd, lat);
    chk("arst_timeout", rd, 32'h0000_0400);
    wb_xfer(1'b0, 4'h4, 32'h0, rd, lat);
    chk("arst_status", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
